// File: rtl/ram_arbiter.sv
// Round-robin arbiter multiplexing NCH write and NCH read byte ring buffers onto one external RAM.
// Latency: ack in the grant cycle, RAM strobes one cycle later, read data strobe two cycles after the grant.
// Backpressure: requesters hold their request until acked; full, empty and flushing channels are skipped.
//
// Ports:
//   i_clk, i_rst                   clock, asynchronous active-low reset
//   i_wr_req/i_wr_data/o_wr_ack    per-channel byte write request, data and one-hot grant
//   i_rd_req/o_rd_ack              per-channel byte read request and one-hot grant
//   o_rd_valid/o_rd_data           one-hot read-data strobe and the returned byte
//   i_flush                        per-channel pointer and count clear
//   o_full/o_empty                 per-channel ring status
//   o_addr/o_D/i_D/WE/RE           external synchronous RAM port
module ram_arbiter #(
    parameter int NCH       = 10,
    parameter int DEPTH     = 1024,
    parameter int ADDRWIDTH = 23
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NCH-1:0]       i_wr_req,
    input  logic [8*NCH-1:0]     i_wr_data,
    input  logic [NCH-1:0]       i_rd_req,
    input  logic [NCH-1:0]       i_flush,
    output logic [NCH-1:0]       o_wr_ack,
    output logic [NCH-1:0]       o_rd_ack,
    output logic [NCH-1:0]       o_rd_valid,
    output logic [7:0]           o_rd_data,
    output logic [NCH-1:0]       o_full,
    output logic [NCH-1:0]       o_empty,
    output logic [ADDRWIDTH-1:0] o_addr,
    output logic [7:0]           o_D,
    input  logic [7:0]           i_D,
    output logic                 WE,
    output logic                 RE
);
    localparam int NSLOT = 2 * NCH;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int SW    = $clog2(NSLOT);
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;

    logic [SW-1:0]  r_rr;
    logic [PW-1:0]  r_wptr [NCH];
    logic [PW-1:0]  r_rptr [NCH];
    logic [CW-1:0]  r_cnt  [NCH];
    logic           r_rd_pend;
    logic [CHW-1:0] r_rd_ch;
    logic [NCH-1:0] r_rd_valid;

    logic [NSLOT-1:0]     w_elig;
    logic                 w_gnt;
    logic [SW-1:0]        w_slot;
    logic                 w_is_rd;
    logic [CHW-1:0]       w_ch;
    logic [PW-1:0]        w_ptr;
    logic [7:0]           w_wdat;
    logic [ADDRWIDTH-1:0] w_addr;

    // Status comes straight from the registered counts, so reset forces empty=1, full=0.
    always_comb begin
        o_full  = '0;
        o_empty = '0;
        for (int k = 0; k < NCH; k++) begin
            o_full[k]  = (r_cnt[k] == CW'(DEPTH));
            o_empty[k] = (r_cnt[k] == '0);
        end
    end

    // Slot layout: writes in the low half, reads in the high half.
    assign w_elig = {i_rd_req & ~o_empty & ~i_flush, i_wr_req & ~o_full & ~i_flush};

    // First eligible slot at or after r_rr, wrapping around the slot ring.
    always_comb begin
        int j;
        j      = 0;
        w_gnt  = 1'b0;
        w_slot = '0;
        for (int i = 0; i < NSLOT; i++) begin
            j = int'(r_rr) + i;
            if (j >= NSLOT) j = j - NSLOT;
            if (!w_gnt && w_elig[j]) begin
                w_gnt  = 1'b1;
                w_slot = SW'(j);
            end
        end
    end

    assign w_is_rd = (w_slot >= SW'(NCH));
    assign w_ch    = w_is_rd ? CHW'(w_slot - SW'(NCH)) : CHW'(w_slot);

    always_comb begin
        o_wr_ack = '0;
        o_rd_ack = '0;
        w_ptr    = '0;
        w_wdat   = '0;
        for (int k = 0; k < NCH; k++) begin
            o_wr_ack[k] = w_gnt && !w_is_rd && (w_ch == CHW'(k));
            o_rd_ack[k] = w_gnt &&  w_is_rd && (w_ch == CHW'(k));
            if (w_ch == CHW'(k)) begin
                w_ptr  = w_is_rd ? r_rptr[k] : r_wptr[k];
                w_wdat = i_wr_data[8*k +: 8];
            end
        end
    end

    // DEPTH is a power of two, so k*DEPTH + ptr is a plain concatenation.
    assign w_addr = ADDRWIDTH'({w_ch, w_ptr});

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rr       <= '0;
            WE         <= 1'b0;
            RE         <= 1'b0;
            o_addr     <= '0;
            o_D        <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_ch    <= '0;
            r_rd_valid <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_wptr[k] <= '0;
                r_rptr[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            WE <= w_gnt && !w_is_rd;
            RE <= w_gnt &&  w_is_rd;
            if (w_gnt) begin
                r_rr   <= (w_slot == SW'(NSLOT - 1)) ? '0 : w_slot + SW'(1);
                o_addr <= w_addr;
                if (!w_is_rd) o_D <= w_wdat;
            end

            // RAM returns data the cycle after RE; the strobe lines up with that cycle.
            // A flush leaves these in-flight reads untouched.
            r_rd_pend <= w_gnt && w_is_rd;
            r_rd_ch   <= w_ch;
            for (int k = 0; k < NCH; k++) begin
                r_rd_valid[k] <= r_rd_pend && (r_rd_ch == CHW'(k));
            end

            for (int k = 0; k < NCH; k++) begin
                if (i_flush[k]) begin
                    r_wptr[k] <= '0;
                    r_rptr[k] <= '0;
                    r_cnt[k]  <= '0;
                end else if (o_wr_ack[k]) begin
                    r_wptr[k] <= r_wptr[k] + PW'(1);
                    r_cnt[k]  <= r_cnt[k] + CW'(1);
                end else if (o_rd_ack[k]) begin
                    r_rptr[k] <= r_rptr[k] + PW'(1);
                    r_cnt[k]  <= r_cnt[k] - CW'(1);
                end
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    // RAM data is live only in the strobe cycle; otherwise the bus reads as zero.
    assign o_rd_data  = (|r_rd_valid) ? i_D : 8'h00;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small synchronous RAM model.
// Latency: checks ack in the grant cycle, RAM strobes at +1, read strobe at +2.
// Backpressure: requests are held until acked, full/flush cases check for absent acks.
module tb_ram_arbiter;
    localparam int NCH   = 10;
    localparam int DEPTH = 1024;
    localparam int AW    = 23;

    logic              i_clk;
    logic              i_rst;
    logic [NCH-1:0]    i_wr_req;
    logic [8*NCH-1:0]  i_wr_data;
    logic [NCH-1:0]    i_rd_req;
    logic [NCH-1:0]    i_flush;
    logic [NCH-1:0]    o_wr_ack;
    logic [NCH-1:0]    o_rd_ack;
    logic [NCH-1:0]    o_rd_valid;
    logic [7:0]        o_rd_data;
    logic [NCH-1:0]    o_full;
    logic [NCH-1:0]    o_empty;
    logic [AW-1:0]     o_addr;
    logic [7:0]        o_D;
    logic [7:0]        i_D;
    logic              WE;
    logic              RE;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] mem [0:NCH*DEPTH-1];

    ram_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .ADDRWIDTH(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wr_req(i_wr_req), .i_wr_data(i_wr_data),
        .i_rd_req(i_rd_req), .i_flush(i_flush),
        .o_wr_ack(o_wr_ack), .o_rd_ack(o_rd_ack),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .o_full(o_full), .o_empty(o_empty),
        .o_addr(o_addr), .o_D(o_D), .i_D(i_D),
        .WE(WE), .RE(RE)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Synchronous RAM: read data appears the cycle after RE.
    always @(posedge i_clk) begin
        if (WE) mem[o_addr] <= o_D;
        if (RE) i_D <= mem[o_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int acks;
        logic [NCH-1:0] seen;
        i_rst     = 1'b0;
        i_wr_req  = '0;
        i_wr_data = '0;
        i_rd_req  = '0;
        i_flush   = '0;
        i_D       = '0;

        // Reset state
        tick(); tick();
        check("rst_empty", 32'(o_empty), 32'h3FF);
        check("rst_full",  32'(o_full),  32'h0);
        check("rst_we_re", {30'd0, WE, RE}, 32'h0);
        check("rst_addr",  32'(o_addr),  32'h0);
        check("rst_rdv",   32'(o_rd_valid), 32'h0);
        i_rst = 1'b1;

        // Single write to channel 3
        i_wr_req[3]        = 1'b1;
        i_wr_data[8*3 +: 8] = 8'h5A;
        #1;
        check("wr3_ack", 32'(o_wr_ack), 32'h008);
        tick();
        i_wr_req = '0;
        #1;
        check("wr3_we",    {31'd0, WE}, 32'h1);
        check("wr3_addr",  32'(o_addr), 32'd3072);
        check("wr3_d",     32'(o_D),    32'h5A);
        check("wr3_empty", {31'd0, o_empty[3]}, 32'h0);

        // Read back from channel 3
        i_rd_req[3] = 1'b1;
        #1;
        check("rd3_ack", 32'(o_rd_ack), 32'h008);
        tick();
        i_rd_req = '0;
        #1;
        check("rd3_re",    {30'd0, WE, RE}, 32'h1);
        check("rd3_addr",  32'(o_addr), 32'd3072);
        check("rd3_empty", {31'd0, o_empty[3]}, 32'h1);
        tick();
        check("rd3_valid", 32'(o_rd_valid), 32'h008);
        check("rd3_data",  32'(o_rd_data),  32'h5A);
        tick();
        check("rd3_valid_end", 32'(o_rd_valid), 32'h0);

        // Prefill: two writes per channel (pointer ends at slot 10), then read ch9 to park pointer at 0
        i_wr_req = '1;
        for (int i = 0; i < 20; i++) tick();
        i_wr_req = '0;
        i_rd_req = 10'h200;
        #1;
        check("park_ack", 32'(o_rd_ack), 32'h200);
        tick();
        i_rd_req = '0;

        // All 20 requesters active: strict slot order 0..19 then 0
        i_wr_req = '1;
        i_rd_req = '1;
        for (int i = 0; i < 21; i++) begin
            #1;
            check($sformatf("rr_slot%0d", i), 32'({o_rd_ack, o_wr_ack}), 32'd1 << (i % 20));
            tick();
        end
        i_wr_req = '0;
        i_rd_req = '0;

        // Flush with a simultaneous write on channel 2
        i_flush[2]  = 1'b1;
        i_wr_req[2] = 1'b1;
        #1;
        check("flush_noack", 32'(o_wr_ack), 32'h0);
        tick();
        i_flush  = '0;
        i_wr_req = '0;
        #1;
        check("flush_empty", {31'd0, o_empty[2]}, 32'h1);
        check("flush_nowe",  {31'd0, WE}, 32'h0);

        // Fill channel 0 from a clean pointer
        i_flush[0] = 1'b1;
        tick();
        i_flush  = '0;
        acks     = 0;
        i_wr_req = 10'h001;
        for (int i = 0; i < DEPTH; i++) begin
            i_wr_data[7:0] = 8'(i) ^ 8'hA5;
            #1;
            if (o_wr_ack == 10'h001) acks++;
            tick();
        end
        check("fill_acks", 32'(acks), 32'd1024);
        check("fill_addr", 32'(o_addr), 32'd1023);
        check("fill_d",    32'(o_D),    32'h5A);
        check("fill_full", {31'd0, o_full[0]}, 32'h1);
        check("full_noack", 32'(o_wr_ack), 32'h0);
        tick();
        check("full_noack2", 32'(o_wr_ack), 32'h0);
        check("full_nowe",   {31'd0, WE}, 32'h0);
        i_wr_req = '0;
        i_rd_req = 10'h001;
        #1;
        check("full_rd_ack", 32'(o_rd_ack), 32'h001);
        tick();
        i_rd_req = '0;
        #1;
        check("full_rd_addr", 32'(o_addr), 32'd0);
        check("full_rd_re",   {31'd0, RE}, 32'h1);
        check("full_cleared", {31'd0, o_full[0]}, 32'h0);
        tick();
        check("full_rd_data", 32'(o_rd_data), 32'hA5);

        // Reset one cycle after a read grant on channel 1
        tick();
        i_rd_req[1] = 1'b1;
        #1;
        check("rst_rd_ack", 32'(o_rd_ack), 32'h002);
        tick();
        i_rd_req = '0;
        i_rst    = 1'b0;
        #1;
        check("rst_mid_we_re", {30'd0, WE, RE}, 32'h0);
        check("rst_mid_empty", 32'(o_empty), 32'h3FF);
        tick();
        i_rst = 1'b1;
        seen  = '0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | o_rd_valid;
            tick();
        end
        check("rst_no_rdv", 32'(seen), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 10: number of channels, each with one write requester and one read requester.
REQ-002 SHALL have parameter DEPTH, default 1024: bytes per channel ring region (power of two).
REQ-003 SHALL have parameter ADDRWIDTH, default 23: external RAM address width.
REQ-004 SHALL have port i_clk  in  1: single clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port i_rst  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port i_wr_req  in  NCH: per-channel write request, held until acked.
REQ-007 SHALL have port i_wr_data  in  8*NCH: per-channel write byte; channel k uses bits [8k+7:8k].
REQ-008 SHALL have port i_rd_req  in  NCH: per-channel read request, held until acked.
REQ-009 SHALL have port i_flush  in  NCH: per-channel pointer clear.
REQ-010 SHALL have port o_wr_ack  out  NCH: one-hot write grant, combinational in the grant cycle.
REQ-011 SHALL have port o_rd_ack  out  NCH: one-hot read grant, combinational in the grant cycle.
REQ-012 SHALL have port o_rd_valid  out  NCH: one-hot read-data strobe.
REQ-013 SHALL have port o_rd_data  out  8: read byte, qualified by o_rd_valid.
REQ-014 SHALL have port o_full  out  NCH: channel count equals DEPTH.
REQ-015 SHALL have port o_empty  out  NCH: channel count equals 0.
REQ-016 SHALL have port o_addr  out  ADDRWIDTH: RAM address.
REQ-017 SHALL have port o_D  out  8: RAM write data.
REQ-018 SHALL have port i_D  in  8: RAM read data, valid one cycle after RE.
REQ-019 SHALL have ports WE and RE  out  1 each: RAM write and read strobes.

Function
REQ-020 SHALL arbitrate 2*NCH slots (slots 0..NCH-1 = writes, slots NCH..2NCH-1 = reads) round-robin, starting the search at pointer rr.
REQ-021 SHALL treat a write slot as eligible iff i_wr_req[k] && !o_full[k] && !i_flush[k].
REQ-022 SHALL treat a read slot as eligible iff i_rd_req[k] && !o_empty[k] && !i_flush[k].
REQ-023 SHALL grant at most one slot per cycle: the first eligible slot at or after rr, modulo 2*NCH.
REQ-024 SHALL, on a grant of slot s in cycle N, set rr to (s+1) mod 2*NCH; with no grant, rr holds.
REQ-025 SHALL assert the matching o_wr_ack or o_rd_ack bit in cycle N only.
REQ-026 SHALL register RAM outputs: in cycle N+1, o_addr = k*DEPTH + ptr; a write drives WE=1 and o_D = i_wr_data[k] sampled in cycle N; a read drives RE=1.
REQ-027 SHALL, on a read grant in cycle N, pulse o_rd_valid[k] in cycle N+2 with o_rd_data = i_D.
REQ-028 SHALL drive WE=RE=0 in non-grant cycles, with o_addr and o_D holding their last values.
REQ-029 SHALL keep per-channel wptr and rptr (log2 DEPTH bits each, wrapping DEPTH-1 -> 0) and count (log2 DEPTH + 1 bits).
REQ-030 SHALL, at the grant edge: on a write, increment wptr and count; on a read, increment rptr and decrement count.
REQ-031 SHALL derive o_full and o_empty combinationally from the registered count.
REQ-032 SHALL, when i_flush[k]=1, zero wptr, rptr and count of channel k at the next edge; flush overrides any request on that channel in that cycle.
REQ-033 SHALL NOT cancel an already-issued RAM access or pending o_rd_valid when a flush occurs.
REQ-034 SHALL guarantee that a continuously requesting eligible slot is granted within 2*NCH cycles.

Reset
REQ-035 SHALL, on i_rst=0, asynchronously clear rr, all pointers and counts, and WE, RE, o_addr, o_D, o_rd_valid and o_rd_data.
REQ-036 SHALL, under reset, drive o_empty all ones and o_full all zeros.
REQ-037 SHALL discard a read in flight when reset is asserted, producing no o_rd_valid after reset release.

Verification
REQ-038 Bench SHALL cover: reset release, i_wr_req[3]=1, data 0x5A -> o_wr_ack[3] in cycle 0; next cycle o_addr=3072, WE=1, o_D=0x5A; o_empty[3] falls.
REQ-039 Bench SHALL cover: after REQ-038, i_rd_req[3]=1 with RAM returning 0x5A -> RE=1, o_addr=3072 at N+1; o_rd_valid[3]=1 and o_rd_data=0x5A at N+2; o_empty[3]=1.
REQ-040 Bench SHALL cover: all 20 requests held high, channels non-empty and non-full -> grants in slot order 0,1,...,19,0; exactly one per cycle.
REQ-041 Bench SHALL cover: 1024 writes to channel 0 -> o_full[0]=1 and further write requests un-acked; the last address is 1023; a following read uses address 0.
REQ-042 Bench SHALL cover: i_flush[2] with i_wr_req[2] in the same cycle -> no ack, and count[2]=0 next cycle.
REQ-043 Bench SHALL cover: reset asserted one cycle after a read grant -> WE=RE=0 immediately, and no o_rd_valid afterwards.
